// File: rtl/bcd2bin_if.sv
`default_nettype none
// ============================================================================
// bcd2bin_if : request/result bundle for the BCD-to-binary converter
// Revision   : 1.0
// ============================================================================
interface bcd2bin_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  busy;
  logic                  rdy;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  bin_out, busy, rdy, err
  );

  modport slave (
    input  start, bcd_in,
    output bin_out, busy, rdy, err
  );
endinterface
`default_nettype wire

// File: rtl/bcd2bin.sv
`default_nettype none
// ============================================================================
// bcd2bin  : sequential BCD-to-binary converter (reverse double dabble)
// Revision : 1.0
// ============================================================================
module bcd2bin #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  bcd2bin_if.slave   bus
);
  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_SCR_W = c_BCD_W + BIN_W;
  localparam int c_CNT_W = $clog2(BIN_W + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SHIFT  = 2'd1;
  localparam logic [1:0] c_ST_ADJUST = 2'd2;
  localparam logic [1:0] c_ST_DONE   = 2'd3;

  logic [1:0]          r_state;
  logic [c_SCR_W-1:0]  r_scratch;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_err_pend;
  logic [BIN_W-1:0]    r_bin_out;
  logic                r_busy;
  logic                r_rdy;
  logic                r_err;

  logic [DIGITS-1:0]   w_digit_bad;
  logic [c_BCD_W-1:0]  w_adj_bcd;

  // Per-digit input validation and the parallel -3 correction of the bcd field
  for (genvar i = 0; i < DIGITS; i++) begin : g_nib
    logic [3:0] w_nib;
    assign w_nib           = r_scratch[BIN_W + 4*i +: 4];
    assign w_digit_bad[i]  = (bus.bcd_in[4*i +: 4] > 4'd9);
    assign w_adj_bcd[4*i +: 4] = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_err_pend <= 1'b0;
      r_bin_out  <= '0;
      r_busy     <= 1'b0;
      r_rdy      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_rdy <= 1'b0;
          if (bus.start) begin
            r_busy <= 1'b1;
            if (|w_digit_bad) begin
              r_err_pend <= 1'b1;
              r_state    <= c_ST_DONE;
            end else begin
              r_err_pend <= 1'b0;
              r_scratch  <= {bus.bcd_in, {BIN_W{1'b0}}};
              r_cnt      <= '0;
              r_state    <= c_ST_SHIFT;
            end
          end
        end
        c_ST_SHIFT: begin
          r_scratch <= r_scratch >> 1;
          r_cnt     <= r_cnt + 1'b1;
          r_state   <= c_ST_ADJUST;
        end
        c_ST_ADJUST: begin
          r_scratch <= {w_adj_bcd, r_scratch[BIN_W-1:0]};
          r_state   <= (r_cnt == c_LAST) ? c_ST_DONE : c_ST_SHIFT;
        end
        c_ST_DONE: begin
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_ST_IDLE;
          if (r_err_pend) begin
            r_bin_out <= '0;
            r_err     <= 1'b1;
          end else begin
            r_bin_out <= r_scratch[BIN_W-1:0];
            r_err     <= 1'b0;
`ifndef SYNTHESIS
            // A fully converted word leaves nothing behind in the bcd field
            assert (r_scratch[c_SCR_W-1:BIN_W] == '0);
`endif
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_busy  <= 1'b0;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bin_out = r_bin_out;
  assign bus.busy    = r_busy;
  assign bus.rdy     = r_rdy;
  assign bus.err     = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bcd2bin.sv
`default_nettype none
// ============================================================================
// tb_bcd2bin : directed + randomized bench for bcd2bin against a decimal model
// Revision   : 1.0
// ============================================================================
module tb_bcd2bin;
  localparam int DIGITS  = 3;
  localparam int BIN_W   = 10;
  localparam int LAT_OK  = 2 * BIN_W + 1;
  localparam int LAT_ERR = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd2bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Decimal reading of a packed BCD word; any digit above 9 marks it invalid
  function automatic void model(input logic [11:0] v, output int bin, output bit bad);
    bin = 0;
    bad = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int d;
      d = int'((v >> (4 * i)) & 12'hF);
      if (d > 9) bad = 1'b1;
      bin = bin * 10 + d;
    end
    if (bad) bin = 0;
  endfunction

  // Called #1 after the accepting edge; waits for rdy and checks the result
  task automatic await_result(input logic [11:0] v, input string tag);
    int bin;
    bit bad;
    int cyc;
    int busy_low;
    model(v, bin, bad);
    cyc = 0;
    busy_low = 0;
    while (bus.rdy !== 1'b1 && cyc < 200) begin
      if (bus.busy !== 1'b1) busy_low++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, bad ? LAT_ERR : LAT_OK);
    check({tag, "_busy_held"}, busy_low, 0);
    check({tag, "_bin_out"}, 32'(bus.bin_out), bin);
    check({tag, "_err"}, 32'(bus.err), 32'(bad));
    check({tag, "_busy_clr"}, 32'(bus.busy), 0);
  endtask

  task automatic do_job(input logic [11:0] v, input string tag);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    await_result(v, tag);
    @(posedge clk); #1;
    check({tag, "_rdy_pulse"}, 32'(bus.rdy), 0);
  endtask

  initial begin
    int cyc;
    int rdy_seen;
    logic [11:0] v;
    int pos;

    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bin_out", 32'(bus.bin_out), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_rdy", 32'(bus.rdy), 0);
    check("reset_err", 32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_job(12'h999, "max_999");
    do_job(12'h000, "zero");
    do_job(12'h255, "loopback_255");
    do_job(12'h0A5, "invalid_0A5");
    do_job(12'h042, "after_err_042");

    // Continuous start with bcd_in wandering; results must track the captured words only
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 12'h123;
    @(posedge clk); #1;
    cyc = 0;
    while (bus.rdy !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      bus.bcd_in = (cyc % 2 == 1) ? 12'h123 : 12'h456;
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_first_latency", cyc, LAT_OK);
    check("b2b_first_bin_out", 32'(bus.bin_out), 123);
    @(negedge clk);
    bus.bcd_in = 12'h456;
    @(posedge clk); #1;
    check("b2b_rdy_one_cycle", 32'(bus.rdy), 0);
    check("b2b_accept_in_rdy_cycle", 32'(bus.busy), 1);
    cyc = 0;
    while (bus.rdy !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      bus.bcd_in = (cyc % 2 == 1) ? 12'h456 : 12'h123;
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_second_latency", cyc, LAT_OK);
    check("b2b_second_bin_out", 32'(bus.bin_out), 456);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("b2b_second_rdy_pulse", 32'(bus.rdy), 0);
    check("b2b_idle_after", 32'(bus.busy), 0);

    // Reset asserted during iteration 5 of a conversion
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 12'h777;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_bin_out", 32'(bus.bin_out), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_rdy", 32'(bus.rdy), 0);
    check("abort_err", 32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.rdy === 1'b1) rdy_seen++;
    end
    check("abort_no_rdy", rdy_seen, 0);
    do_job(12'h777, "after_abort_777");

    // Randomized valid and invalid words
    for (int i = 0; i < 40; i++) begin
      v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      do_job(v, "rand_valid");
    end
    for (int i = 0; i < 60; i++) begin
      v = 12'($urandom);
      pos = int'($urandom_range(0, DIGITS - 1));
      v[4*pos +: 4] = 4'($urandom_range(10, 15));
      do_job(v, "rand_invalid");
    end

    // Exhaustive sweep of every valid three-digit word
    for (int n = 0; n < 1000; n++) begin
      v = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
      do_job(v, "sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
